// File: rtl/multicycle_cpu_if.sv
// rtl/multicycle_cpu_if.sv - Load/status bundle between a host and multicycle_cpu
//
// Ports (signals of the bundle):
//   initialize                      host -> core  hold core idle and write imem
//   instruction_initialize_data     host -> core  instruction word to store
//   instruction_initialize_address  host -> core  byte address of that word
//   pc_out                          core -> host  current program counter
//   state_out                       core -> host  control state (IDLE=0 .. HALT=6)
//   retire                          core -> host  one-cycle pulse per completed instruction
//   retire_count                    core -> host  wrapping count of retired instructions
//   halted                          core -> host  high while the core sits in HALT
interface multicycle_cpu_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 initialize;
    logic [31:0]          instruction_initialize_data;
    logic [31:0]          instruction_initialize_address;
    logic [31:0]          pc_out;
    logic [2:0]           state_out;
    logic                 retire;
    logic [CNT_WIDTH-1:0] retire_count;
    logic                 halted;

    modport master (
        output initialize, instruction_initialize_data, instruction_initialize_address,
        input  pc_out, state_out, retire, retire_count, halted
    );

    modport slave (
        input  initialize, instruction_initialize_data, instruction_initialize_address,
        output pc_out, state_out, retire, retire_count, halted
    );
endinterface

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - Multi-cycle MIPS-subset core with HALT state and retire counter
//
// Ports:
//   clk  in   rising-edge clock for all state
//   rst  in   asynchronous active-low reset (clears core state and register file,
//             keeps instruction and data memory contents)
//   bus  slave modport of multicycle_cpu_if: imem load port plus pc/state/retire/halt status
module multicycle_cpu #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    multicycle_cpu_if.slave bus
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state, state_next;

    logic [31:0]           pc, ir;
    logic [DATA_WIDTH-1:0] a, b, alu_out, mdr;
    logic [DATA_WIDTH-1:0] rf   [32];
    logic [31:0]           imem [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] dmem [DMEM_DEPTH];
    logic                  retire;
    logic [CNT_WIDTH-1:0]  retire_count;

    logic                  retire_set, pc_branch, pc_jump, rf_we, dmem_we, op_known;
    logic [DATA_WIDTH-1:0] exec_result, imm_sext, wb_data;
    logic [31:0]           branch_target, jump_target;
    logic [5:0]            opcode, funct;
    logic [4:0]            rs, rt, rd, dest;
    logic [15:0]           imm;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

    assign imm_sext      = DATA_WIDTH'($signed(imm));
    // pc already points past the branch when DECODE computes this
    assign branch_target = pc + (32'($signed(imm)) << 2);
    assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
    assign dest          = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data       = (opcode == OP_LW) ? mdr : alu_out;

    // Address bits outside the word index are ignored, so imem aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.instruction_initialize_address[31:IA+2],
                                bus.instruction_initialize_address[1:0]};

    always_comb begin
        op_known = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    always_comb begin
        exec_result = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    6'h20:   exec_result = a + b;
                    6'h22:   exec_result = a - b;
                    6'h24:   exec_result = a & b;
                    6'h25:   exec_result = a | b;
                    6'h2A:   exec_result = DATA_WIDTH'($signed(a) < $signed(b));
                    default: exec_result = '0;
                endcase
            end
            OP_LUI:  exec_result = DATA_WIDTH'({imm, 16'h0000});
            default: exec_result = a + imm_sext;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // initialize overrides every state, which also blocks the write strobes below.
    always_comb begin
        state_next = state;
        retire_set = 1'b0;
        pc_branch  = 1'b0;
        pc_jump    = 1'b0;
        rf_we      = 1'b0;
        dmem_we    = 1'b0;
        if (bus.initialize) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_next = S_FETCH;
                S_FETCH: state_next = S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state_next = S_HALT;
                    end else if (!op_known) begin
                        retire_set = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_BEQ: begin
                            pc_branch  = (a == b);
                            retire_set = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_BNE: begin
                            pc_branch  = (a != b);
                            retire_set = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_J: begin
                            pc_jump    = 1'b1;
                            retire_set = 1'b1;
                            state_next = S_FETCH;
                        end
                        OP_LW, OP_SW: state_next = S_MEM;
                        default:      state_next = S_WB;
                    endcase
                end
                S_MEM: begin
                    if (opcode == OP_SW) begin
                        dmem_we    = 1'b1;
                        retire_set = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    retire_set = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= '0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            retire       <= 1'b0;
            retire_count <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.initialize) begin
            pc     <= '0;
            retire <= 1'b0;
        end else begin
            retire <= retire_set;
            if (retire_set) begin
                retire_count <= retire_count + CNT_WIDTH'(1);
            end
            case (state)
                S_FETCH: begin
                    ir <= imem[pc[IA+1:2]];
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= DATA_WIDTH'(branch_target);
                end
                S_EXEC: begin
                    // branches consume the target latched in DECODE before it is overwritten
                    alu_out <= exec_result;
                    if (pc_branch) begin
                        pc <= 32'(alu_out);
                    end else if (pc_jump) begin
                        pc <= jump_target;
                    end
                end
                S_MEM: mdr <= dmem[alu_out[DA+1:2]];
                S_WB: begin
                    if (rf_we && dest != 5'd0) begin
                        rf[dest] <= wb_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.initialize) begin
            imem[bus.instruction_initialize_address[IA+1:2]] <= bus.instruction_initialize_data;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[alu_out[DA+1:2]] <= b;
        end
    end

    assign bus.pc_out       = pc;
    assign bus.state_out    = state;
    assign bus.retire       = retire;
    assign bus.retire_count = retire_count;
    assign bus.halted       = (state == S_HALT);
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - Self-checking bench for multicycle_cpu against an ISA-level model
module tb_multicycle_cpu;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_cpu_if #(.CNT_WIDTH(16)) bus_if ();

    multicycle_cpu #(
        .DATA_WIDTH(32), .IMEM_DEPTH(64), .DMEM_DEPTH(64), .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog   [64];
    logic [31:0] mregs  [32];
    logic [31:0] mdmem  [64];
    bit          dvalid [64];
    int          mcount;
    int          exp_cycles, exp_retires;
    logic [31:0] exp_pc;
    int          trace_state  [512];
    bit          trace_retire [512];
    int          run_cycles;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic mwrite(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) mregs[idx] = v;
    endtask

    // Instruction-level interpreter: architectural effect plus documented cycle cost.
    task automatic model_run();
        logic [31:0] pc, ins, a, b, simm, addr, r;
        bit          done;
        int          steps;
        pc = 0; exp_cycles = 0; exp_retires = 0; done = 0; steps = 0;
        while (!done && steps < 1000) begin
            steps++;
            ins  = prog[pc[7:2]];
            pc   = pc + 4;
            a    = mregs[ins[25:21]];
            b    = mregs[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            addr = a + simm;
            case (ins[31:26])
                6'h3F: begin exp_cycles += 2; done = 1; end
                6'h00: begin
                    case (ins[5:0])
                        6'h20:   r = a + b;
                        6'h22:   r = a - b;
                        6'h24:   r = a & b;
                        6'h25:   r = a | b;
                        6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: r = 32'd0;
                    endcase
                    mwrite(ins[15:11], r);
                    exp_cycles += 4; exp_retires++;
                end
                6'h08: begin mwrite(ins[20:16], addr); exp_cycles += 4; exp_retires++; end
                6'h0F: begin mwrite(ins[20:16], {ins[15:0], 16'h0}); exp_cycles += 4; exp_retires++; end
                6'h23: begin mwrite(ins[20:16], mdmem[addr[7:2]]); exp_cycles += 5; exp_retires++; end
                6'h2B: begin
                    mdmem[addr[7:2]] = b; dvalid[addr[7:2]] = 1;
                    exp_cycles += 4; exp_retires++;
                end
                6'h04: begin if (a == b) pc = pc + (simm << 2); exp_cycles += 3; exp_retires++; end
                6'h05: begin if (a != b) pc = pc + (simm << 2); exp_cycles += 3; exp_retires++; end
                6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; exp_cycles += 3; exp_retires++; end
                default: begin exp_cycles += 2; exp_retires++; end
            endcase
        end
        exp_pc = pc;
        mcount += exp_retires;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus_if.initialize = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 0;
    endtask

    task automatic clear_prog();
        for (int w = 0; w < 64; w++) prog[w] = HALT_W;
    endtask

    task automatic load_program();
        logic [31:0] hi;
        @(negedge clk);
        bus_if.initialize = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 64; w++) begin
            hi = $urandom;
            bus_if.instruction_initialize_address = {hi[31:8], 6'(w), hi[1:0]};
            bus_if.instruction_initialize_data    = prog[w];
            @(negedge clk);
        end
    endtask

    task automatic run_program(input string name);
        int          pulses;
        logic [31:0] pc_hold;
        model_run();
        @(negedge clk);
        bus_if.initialize = 1'b0;
        run_cycles = -1;
        pulses = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            trace_state[k]  = int'(bus_if.state_out);
            trace_retire[k] = bus_if.retire;
            if (bus_if.retire) pulses++;
            if (bus_if.state_out == 3'd6) begin
                run_cycles = k;
                break;
            end
        end
        checks++;
        if (run_cycles < 0) begin
            errors++;
            $display("FAIL %s halt_timeout: state %0d never reached HALT(6)", name, bus_if.state_out);
        end
        checks++;
        if (run_cycles != exp_cycles) begin
            errors++;
            $display("FAIL %s cycles: got %0d expected %0d", name, run_cycles, exp_cycles);
        end
        checks++;
        if (pulses != exp_retires) begin
            errors++;
            $display("FAIL %s retire_pulses: got %0d expected %0d", name, pulses, exp_retires);
        end
        checks++;
        if (bus_if.retire_count !== 16'(mcount)) begin
            errors++;
            $display("FAIL %s retire_count: got %0d expected %0d", name, bus_if.retire_count, mcount);
        end
        checks++;
        if (bus_if.pc_out !== exp_pc || bus_if.halted !== 1'b1) begin
            errors++;
            $display("FAIL %s pc/halted: got %h/%b expected %h/1", name, bus_if.pc_out, bus_if.halted, exp_pc);
        end
        pc_hold = bus_if.pc_out;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.pc_out !== pc_hold || bus_if.state_out !== 3'd6 || bus_if.retire !== 1'b0) begin
            errors++;
            $display("FAIL %s halt_hold: pc %h state %0d retire %b expected pc %h state 6 retire 0",
                     name, bus_if.pc_out, bus_if.state_out, bus_if.retire, pc_hold);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.rf[i] !== mregs[i]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", name, i, dut.rf[i], mregs[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            if (dvalid[i]) begin
                checks++;
                if (dut.dmem[i] !== mdmem[i]) begin
                    errors++;
                    $display("FAIL %s dmem%0d: got %h expected %h", name, i, dut.dmem[i], mdmem[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus_if.initialize = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.state_out !== 3'd0 || bus_if.pc_out !== 32'd0 || bus_if.retire !== 1'b0 ||
            bus_if.retire_count !== 16'd0 || bus_if.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: state %0d pc %h retire %b count %0d halted %b expected all zero",
                     bus_if.state_out, bus_if.pc_out, bus_if.retire, bus_if.retire_count, bus_if.halted);
        end
        checks++;
        if (dut.rf[7] !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf: got %h expected 0", dut.rf[7]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 0;
        @(negedge clk);
        checks++;
        if (bus_if.state_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: state %0d expected 0", bus_if.state_out);
        end
    endtask

    task automatic test_init_run();
        do_reset();
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[1] = enc_i(6'h08, 0, 2, 16'd7);
        prog[2] = enc_r(1, 2, 3, 6'h20);
        load_program();
        run_program("init_run");
        checks++;
        if (dut.rf[3] !== 32'd12 || bus_if.retire_count !== 16'd3 || bus_if.pc_out !== 32'h10 ||
            run_cycles != 14) begin
            errors++;
            $display("FAIL init_run_fixed: r3 %0d count %0d pc %h cycles %0d expected 12 3 00000010 14",
                     dut.rf[3], bus_if.retire_count, bus_if.pc_out, run_cycles);
        end
    endtask

    task automatic test_memory();
        int exp_seq [5];
        exp_seq = '{1, 2, 3, 4, 5};
        do_reset();
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'h2A);
        prog[1] = enc_i(6'h2B, 0, 1, 16'd8);
        prog[2] = enc_i(6'h23, 0, 4, 16'd8);
        load_program();
        run_program("memory");
        checks++;
        if (dut.rf[4] !== 32'h2A || dut.dmem[2] !== 32'h2A || run_cycles != 15) begin
            errors++;
            $display("FAIL memory_fixed: r4 %h dmem2 %h cycles %0d expected 2a 2a 15",
                     dut.rf[4], dut.dmem[2], run_cycles);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (trace_state[8 + k] != exp_seq[k]) begin
                errors++;
                $display("FAIL lw_state_seq%0d: got %0d expected %0d", k, trace_state[8 + k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_branches();
        do_reset();
        clear_prog();
        prog[0]  = enc_i(6'h04, 0, 0, 16'd1);
        prog[1]  = enc_i(6'h08, 0, 1, 16'd1);
        prog[2]  = enc_i(6'h05, 0, 0, 16'd1);
        prog[3]  = enc_i(6'h08, 0, 2, 16'd2);
        prog[4]  = enc_j(26'h10);
        prog[16] = enc_i(6'h08, 0, 3, 16'd3);
        load_program();
        run_program("branches");
        checks++;
        if (dut.rf[1] !== 32'd0 || dut.rf[2] !== 32'd2 || dut.rf[3] !== 32'd3 ||
            bus_if.pc_out !== 32'h48 || run_cycles != 19) begin
            errors++;
            $display("FAIL branches_fixed: r1 %0d r2 %0d r3 %0d pc %h cycles %0d expected 0 2 3 00000048 19",
                     dut.rf[1], dut.rf[2], dut.rf[3], bus_if.pc_out, run_cycles);
        end
        checks++;
        if (trace_retire[3] !== 1'b1 || trace_state[3] != 1) begin
            errors++;
            $display("FAIL branch_retire_cycle: retire %b state %0d at cycle 3 expected 1 1",
                     trace_retire[3], trace_state[3]);
        end
    endtask

    task automatic test_edge_values();
        do_reset();
        clear_prog();
        prog[0] = enc_i(6'h0F, 0, 5, 16'h8000);
        prog[1] = enc_r(5, 0, 6, 6'h2A);
        prog[2] = enc_r(5, 5, 7, 6'h20);
        prog[3] = enc_i(6'h08, 0, 0, 16'd9);
        load_program();
        run_program("edge");
        checks++;
        if (dut.rf[5] !== 32'h8000_0000 || dut.rf[6] !== 32'd1 || dut.rf[7] !== 32'd0 ||
            dut.rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL edge_fixed: r5 %h r6 %h r7 %h r0 %h expected 80000000 1 0 0",
                     dut.rf[5], dut.rf[6], dut.rf[7], dut.rf[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        bit found;
        do_reset();
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'h33);
        prog[1] = enc_i(6'h2B, 0, 1, 16'd12);
        prog[2] = enc_i(6'h08, 0, 1, 16'h55);
        prog[3] = enc_i(6'h2B, 0, 1, 16'd12);
        load_program();
        @(negedge clk);
        bus_if.initialize = 1'b0;
        seen = 0; found = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (bus_if.state_out == 3'd4) seen++;
            if (seen == 2) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_reach_mem: MEM visits %0d expected 2", seen);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.state_out !== 3'd0 || bus_if.pc_out !== 32'd0 || bus_if.retire_count !== 16'd0 ||
            dut.rf[1] !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_async: state %0d pc %h count %0d r1 %h expected 0 0 0 0",
                     bus_if.state_out, bus_if.pc_out, bus_if.retire_count, dut.rf[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (dut.dmem[3] !== 32'h33) begin
            errors++;
            $display("FAIL rst_mid_no_store: dmem3 %h expected 00000033", dut.dmem[3]);
        end
        bus_if.initialize = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcount = 0;
        mdmem[3] = 32'h33;
        dvalid[3] = 1;
        run_program("rst_rerun");
    endtask

    task automatic test_reinit();
        bit found;
        do_reset();
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'd7);
        load_program();
        @(negedge clk);
        bus_if.initialize = 1'b0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus_if.state_out == 3'd3) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reinit_reach_exec: state %0d expected 3", bus_if.state_out);
        end
        @(negedge clk);
        bus_if.initialize = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.state_out !== 3'd0 || bus_if.pc_out !== 32'd0 || dut.rf[1] !== 32'd0) begin
            errors++;
            $display("FAIL reinit_abort: state %0d pc %h r1 %h expected 0 0 0",
                     bus_if.state_out, bus_if.pc_out, dut.rf[1]);
        end
        clear_prog();
        prog[0] = {6'h3E, 26'h155_5555};
        prog[1] = enc_i(6'h08, 0, 2, 16'd9);
        load_program();
        run_program("reinit");
        checks++;
        if (dut.rf[2] !== 32'd9 || trace_retire[2] !== 1'b1 || trace_state[2] != 1 || run_cycles != 8) begin
            errors++;
            $display("FAIL reinit_nop: r2 %0d retire@2 %b state@2 %0d cycles %0d expected 9 1 1 8",
                     dut.rf[2], trace_retire[2], trace_state[2], run_cycles);
        end
    endtask

    task automatic test_random();
        bit          gvalid [64];
        logic [5:0]  functs [6];
        logic [5:0]  bad_ops [4];
        logic [31:0] rnd;
        int          sel, rs, rt, rd, word, found, start;
        functs  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
        bad_ops = '{6'h3E, 6'h01, 6'h10, 6'h30};
        do_reset();
        for (int p = 0; p < 8; p++) begin
            gvalid = dvalid;
            clear_prog();
            for (int k = 0; k < 14; k++) begin
                sel = $urandom_range(0, 11);
                rs  = $urandom_range(0, 7);
                rt  = $urandom_range(0, 7);
                rd  = $urandom_range(0, 7);
                rnd = $urandom;
                if (sel <= 3) begin
                    prog[k] = enc_r(rs, rt, rd, functs[$urandom_range(0, 5)]);
                end else if (sel <= 5) begin
                    prog[k] = enc_i(6'h08, rs, rt, rnd[15:0]);
                end else if (sel == 6) begin
                    prog[k] = enc_i(6'h0F, 0, rt, rnd[15:0]);
                end else if (sel <= 8) begin
                    word = $urandom_range(0, 15);
                    prog[k] = enc_i(6'h2B, 0, rt, 16'(word * 4 + 256 * $urandom_range(0, 3)));
                    gvalid[word] = 1;
                end else if (sel <= 10) begin
                    found = -1;
                    start = $urandom_range(0, 63);
                    for (int j = 0; j < 64; j++) begin
                        if (found < 0 && gvalid[(start + j) % 64]) found = (start + j) % 64;
                    end
                    if (found >= 0)
                        prog[k] = enc_i(6'h23, 0, rt, 16'(found * 4 + 256 * $urandom_range(0, 3)));
                    else
                        prog[k] = enc_i(6'h08, rs, rt, rnd[15:0]);
                end else begin
                    prog[k] = {bad_ops[$urandom_range(0, 3)], rnd[25:0]};
                end
            end
            load_program();
            run_program($sformatf("random%0d", p));
        end
    endtask

    initial begin
        bus_if.initialize = 1'b1;
        bus_if.instruction_initialize_data = 32'd0;
        bus_if.instruction_initialize_address = 32'd0;
        mcount = 0;
        test_reset();
        test_init_run();
        test_memory();
        test_branches();
        test_edge_values();
        test_reset_mid_op();
        test_reinit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
